// File: rtl/pdm_modulator.sv
// PCM -> PDM converter: zero-order-hold interpolation into a first-order
// error-feedback sigma-delta modulator, one PDM bit every CLK_DIV clocks.
module pdm_modulator #(
  parameter int DATA_BW = 8,
  parameter int OSR     = 250,
  parameter int CLK_DIV = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               en_i,
  input  logic [DATA_BW-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               pdm_o,
  output logic               pdm_valid_o,
  output logic               underrun_o
);

  localparam int ACC_W = DATA_BW + 2;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(OSR);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (DATA_BW - 1));

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state;
  logic [DATA_BW-1:0]        buf_q;
  logic                      buf_full;
  logic [DATA_BW-1:0]        hold_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [DIV_W-1:0]          div_cnt;
  logic [BIT_W-1:0]          bit_cnt;

  logic                      tick;
  logic signed [ACC_W-1:0]   sum;
  logic                      bit_nxt;

  assign ready_o = en_i & rst_n_i & ~buf_full;
  assign tick    = (state == RUN) && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign sum     = acc_q + $signed({{2{hold_q[DATA_BW-1]}}, hold_q});
  assign bit_nxt = ~sum[ACC_W-1];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !en_i) begin
      state       <= IDLE;
      buf_q       <= '0;
      buf_full    <= 1'b0;
      hold_q      <= '0;
      acc_q       <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      pdm_o       <= 1'b0;
      pdm_valid_o <= 1'b0;
      underrun_o  <= 1'b0;
    end else begin
      pdm_valid_o <= 1'b0;
      underrun_o  <= 1'b0;
      // ready_o is low while full, so a load never collides with a drain
      if (valid_i && ready_o) begin
        buf_q    <= data_i;
        buf_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (buf_full) begin
            hold_q   <= buf_q;
            buf_full <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
          if (tick) begin
            acc_q       <= bit_nxt ? sum - HALF : sum + HALF;
            pdm_o       <= bit_nxt;
            pdm_valid_o <= 1'b1;
            // frame end: final bit above used the old hold; swap in the next sample
            if (bit_cnt == BIT_W'(OSR - 1)) begin
              bit_cnt <= '0;
              if (buf_full) begin
                hold_q   <= buf_q;
                buf_full <= 1'b0;
              end else begin
                hold_q     <= '0;
                underrun_o <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_modulator.sv
// Bench for pdm_modulator: directed scenarios with random samples, checked
// against an integer sigma-delta reference and density/timing properties.
module tb_pdm_modulator;
  localparam int DATA_BW = 8;
  localparam int OSR     = 250;
  localparam int CLK_DIV = 4;
  localparam int HALF    = 128;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         valid = 1'b0;
  logic [7:0]   data = '0;
  logic         ready, pdm, pdm_valid, underrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cap = 1'b0;

  bit bits[$];
  int times[$];
  int und[$];
  bit exp_q[$];
  int stim[$];

  pdm_modulator #(.DATA_BW(DATA_BW), .OSR(OSR), .CLK_DIV(CLK_DIV)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .data_i(data), .valid_i(valid),
    .ready_o(ready), .pdm_o(pdm), .pdm_valid_o(pdm_valid), .underrun_o(underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // cyc read here equals the index of the edge that produced the outputs
  always @(negedge clk) begin
    if (cap) begin
      if (pdm_valid) begin
        bits.push_back(pdm);
        times.push_back(cyc);
      end
      if (underrun) und.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    cap = 1'b0; rst_n = 1'b0; valid = 1'b0; en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_rst_pdm"}, pdm, 0);
    chk({tag, "_rst_vld"}, pdm_valid, 0);
    chk({tag, "_rst_und"}, underrun, 0);
    chk({tag, "_rst_rdy"}, ready, 0);
    bits.delete(); times.delete(); und.delete(); stim.delete();
    rst_n = 1'b1; cap = 1'b1;
    #1 chk({tag, "_rdy_after_rst"}, ready, 1);
  endtask

  task automatic send(input int x, output int hs);
    int c = 0;
    @(negedge clk);
    while (!ready && c < 200) begin @(negedge clk); c++; end
    chk("send_ready", ready, 1);
    data = 8'(x); valid = 1'b1;
    hs = cyc + 1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_bits(input string tag, input int n);
    int c = 0;
    while (bits.size() < n && c < 30000) begin @(posedge clk); c++; end
    chk({tag, "_bits_arrived"}, (bits.size() >= n) ? 1 : 0, 1);
  endtask

  // Reference: each frame repeats its sample OSR times (0 once samples run out),
  // modulated by an integer error-feedback loop starting from acc = 0.
  task automatic build_model(input int nframes);
    int acc = 0;
    exp_q.delete();
    for (int f = 0; f < nframes; f++) begin
      int x = (f < stim.size()) ? stim[f] : 0;
      for (int b = 0; b < OSR; b++) begin
        int s = acc + x;
        bit q = (s >= 0);
        acc = q ? s - HALF : s + HALF;
        exp_q.push_back(q);
      end
    end
  endtask

  task automatic cmp_stream(input string tag, input int n);
    int mism = 0;
    for (int i = 0; i < n; i++)
      if (i >= bits.size() || bits[i] !== exp_q[i]) mism++;
    chk(tag, mism, 0);
  endtask

  function automatic int ones_in(input int frame);
    int n = 0;
    for (int i = 0; i < OSR; i++)
      if (frame * OSR + i < bits.size() && bits[frame * OSR + i]) n++;
    return n;
  endfunction

  function automatic int spacing_bad(input int n);
    int bad = 0;
    for (int i = 1; i < n && i < times.size(); i++)
      if (times[i] - times[i-1] != CLK_DIV) bad++;
    return bad;
  endfunction

  function automatic int at_or(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int hs, nb, bad, lead, n, lo, hi, i;

    // zero input: alternating bits, then underrun frames of midscale
    do_reset("s1");
    stim.push_back(0);
    send(0, hs);
    wait_bits("s1", 3 * OSR);
    build_model(3);
    cmp_stream("s1_stream", 3 * OSR);
    chk("s1_first_strobe", at_or(times, 0), hs + 1 + CLK_DIV);
    chk("s1_spacing", spacing_bad(3 * OSR), 0);
    chk("s1_ones", ones_in(0), 125);
    chk("s1_und0_time", at_or(und, 0), times[OSR - 1]);
    chk("s1_und1_time", at_or(und, 1), times[2 * OSR - 1]);

    // positive full scale
    do_reset("s2a");
    stim.push_back(127);
    send(127, hs);
    wait_bits("s2a", OSR);
    build_model(1);
    cmp_stream("s2a_stream", OSR);
    lead = 0;
    while (lead < bits.size() && bits[lead]) lead++;
    chk("s2a_leading_ones", lead, 128);

    // negative full scale
    do_reset("s2b");
    stim.push_back(-128);
    send(-128, hs);
    wait_bits("s2b", OSR);
    chk("s2b_ones", ones_in(0), 0);

    // backpressure: valid held high across a ramp plus random samples
    do_reset("s4");
    for (int v = -126; v <= 126; v += 42) stim.push_back(v);
    repeat (5) stim.push_back(int'($urandom_range(0, 255)) - 128);
    n = stim.size();
    i = 0; bad = 0; nb = 0;
    @(negedge clk);
    data = 8'(stim[0]); valid = 1'b1;
    while (i < n && nb < 20000) begin
      hs = ready;
      @(posedge clk); nb++;
      @(negedge clk);
      if (hs) begin
        if (ready !== 1'b0) bad++;
        i++;
        if (i < n) data = 8'(stim[i]);
      end
    end
    valid = 1'b0;
    chk("s4_all_accepted", i, n);
    chk("s4_ready_low_when_full", bad, 0);
    wait_bits("s4", (n + 1) * OSR);
    build_model(n + 1);
    cmp_stream("s4_stream", (n + 1) * OSR);
    bad = 0;
    for (int f = 0; f < n; f++) begin
      lo = (stim[f] + HALF) * OSR / 256 - 1;
      hi = lo + 2;
      if (ones_in(f) < lo || ones_in(f) > hi) bad++;
    end
    chk("s4_density", bad, 0);
    chk("s4_first_underrun", at_or(und, 0), times[n * OSR - 1]);

    // enable dropped mid-frame with a sample buffered
    do_reset("s5");
    send(0, hs);
    send(77, hs);
    wait_bits("s5", 100);
    @(negedge clk);
    en = 1'b0;
    nb = bits.size();
    repeat (40) @(negedge clk);
    chk("s5_no_strobes", bits.size(), nb);
    chk("s5_no_underrun", und.size(), 0);
    chk("s5_ready_low", ready, 0);
    chk("s5_pdm_cleared", pdm, 0);
    en = 1'b1;
    @(posedge clk);
    bits.delete(); times.delete(); und.delete(); stim.delete();
    stim.push_back(0);
    send(0, hs);
    wait_bits("s5r", 2 * OSR);
    build_model(2);
    cmp_stream("s5_restart_stream", 2 * OSR);
    chk("s5_restart_latency", at_or(times, 0), hs + 1 + CLK_DIV);
    chk("s5_buffer_discarded", at_or(und, 0), times[OSR - 1]);

    // reset pulse mid-frame
    do_reset("s6");
    send(50, hs);
    wait_bits("s6", 60);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("s6_ready_in_rst", ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("s6_pdm", pdm, 0);
    chk("s6_vld", pdm_valid, 0);
    chk("s6_und", underrun, 0);
    nb = bits.size();
    rst_n = 1'b1;
    #1 chk("s6_ready_after", ready, 1);
    en = 1'b0;
    #1 chk("s6_ready_en_low", ready, 0);
    en = 1'b1;
    repeat (20) @(negedge clk);
    chk("s6_idle_after", bits.size(), nb);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
